pixel_frame_sequencer: RTL



---
 rtl/pixel_frame_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the pixel array: erase, expose, ADC ramp convert, then handshaked row readout.
// Defining FRAME_COUNT_EN adds a 16-bit frame_count output that counts frame_done pulses.
module pixel_frame_sequencer #(
  parameter int ROWS            = 2,
  parameter int CNT_W           = 8,
  parameter int ERASE_CYCLES    = 5,
  parameter int READ_ROW_CYCLES = 5,
  parameter int EXP_W           = 16,
  localparam int RI_W           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [EXP_W-1:0] expose_len,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic [CNT_W-1:0] adc_count,
  output logic [ROWS-1:0]  read,
  output logic [RI_W-1:0]  row_idx,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             busy,
`ifdef FRAME_COUNT_EN
  output logic [15:0]      frame_count,
`endif
  output logic             frame_done
);

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} state_t;

  localparam int PH_A = (EXP_W > $clog2(ERASE_CYCLES + 1)) ? EXP_W : $clog2(ERASE_CYCLES + 1);
  localparam int PH_W = (PH_A > $clog2(READ_ROW_CYCLES + 1)) ? PH_A : $clog2(READ_ROW_CYCLES + 1);
  localparam logic [PH_W-1:0]  ERASE_LAST = PH_W'(ERASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  VALID_IDX  = PH_W'(READ_ROW_CYCLES - 1);
  localparam logic [RI_W-1:0]  LAST_ROW   = RI_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ADC_MAX    = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [PH_W-1:0]  cnt, cnt_nxt, cnt_inc, exp_last;
  logic [EXP_W-1:0] exp_len, exp_len_nxt, start_len;
  logic [CNT_W-1:0] adc_nxt;
  logic [ROWS-1:0]  read_nxt;
  logic [RI_W-1:0]  row_idx_nxt;
  logic             erase_nxt, expose_nxt, convert_nxt;
  logic             row_valid_nxt, busy_nxt, frame_done_nxt;
  logic             handshake;

  // A zero exposure request still exposes for one cycle.
  assign start_len = (expose_len == '0) ? EXP_W'(1) : expose_len;
  assign exp_last  = PH_W'(exp_len - EXP_W'(1));
  assign cnt_inc   = cnt + PH_W'(1);
  assign handshake = row_valid & row_ready;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    exp_len_nxt    = exp_len;
    adc_nxt        = '0;
    row_idx_nxt    = row_idx;
    row_valid_nxt  = row_valid;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = ERASE;
          cnt_nxt     = '0;
          exp_len_nxt = start_len;
        end
      end
      ERASE: begin
        if (cnt == ERASE_LAST) begin
          state_nxt = EXPOSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      EXPOSE: begin
        if (cnt == exp_last) begin
          state_nxt = CONVERT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      CONVERT: begin
        if (adc_count == ADC_MAX) begin
          state_nxt     = READ;
          cnt_nxt       = '0;
          row_idx_nxt   = '0;
          row_valid_nxt = (READ_ROW_CYCLES <= 1);
        end else begin
          adc_nxt = adc_count + CNT_W'(1);
        end
      end
      READ: begin
        // The row counter stops once valid is raised; the row then waits on row_ready.
        if (handshake) begin
          cnt_nxt = '0;
          if (row_idx == LAST_ROW) begin
            frame_done_nxt = 1'b1;
            row_valid_nxt  = 1'b0;
            row_idx_nxt    = '0;
            if (continuous) begin
              state_nxt   = ERASE;
              exp_len_nxt = start_len;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            row_idx_nxt   = row_idx + RI_W'(1);
            row_valid_nxt = (READ_ROW_CYCLES <= 1);
          end
        end else if (!row_valid) begin
          cnt_nxt       = cnt_inc;
          row_valid_nxt = (cnt_inc >= VALID_IDX);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    erase_nxt   = (state_nxt == ERASE);
    expose_nxt  = (state_nxt == EXPOSE);
    convert_nxt = (state_nxt == CONVERT);
    busy_nxt    = (state_nxt != IDLE);
    read_nxt    = (state_nxt == READ) ? (ROWS'(1) << row_idx_nxt) : '0;
  end

  // Outputs are registered copies of the next-state decode so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      exp_len     <= '0;
      erase       <= 1'b0;
      expose      <= 1'b0;
      convert     <= 1'b0;
      adc_count   <= '0;
      read        <= '0;
      row_idx     <= '0;
      row_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FRAME_COUNT_EN
      frame_count <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      exp_len     <= exp_len_nxt;
      erase       <= erase_nxt;
      expose      <= expose_nxt;
      convert     <= convert_nxt;
      adc_count   <= adc_nxt;
      read        <= read_nxt;
      row_idx     <= row_idx_nxt;
      row_valid   <= row_valid_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
`ifdef FRAME_COUNT_EN
      if (frame_done_nxt) begin
        frame_count <= frame_count + 16'd1;
      end
`endif
    end
  end

endmodule
